if_stage_unit: RTL and testbench

- Instruction-fetch stage: owns the PC register, drives the instruction-memory/I-cache request and owns the IF/ID pipeline register.
- Consumes the flush unit's reset_IF_reg (branch/jump redirect) and hold_IF_reg (load-use stall).
- Absorbs multi-cycle I-cache stalls. A redirect that arrives during an in-flight fetch is latched and applied once the access completes.

---
 rtl/if_stage_unit.sv | 108 ++++++++++
 tb/tb_if_stage_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_unit.sv
// Instruction-fetch stage: PC register, I-cache request and IF/ID pipeline register.
// Absorbs multi-cycle I-cache stalls; a redirect arriving mid-fetch is parked
// in pending_target_q and applied once the stale access completes.
module if_stage_unit #(
  parameter int                     PC_WIDTH    = 32,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = 32'h0000_0000,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   reset_IF_reg,
  input  logic                   hold_IF_reg,
  input  logic [PC_WIDTH-1:0]    branch_jump_target,
  input  logic                   imem_busywait,
  input  logic [INSTR_WIDTH-1:0] imem_instruction,
  output logic [PC_WIDTH-1:0]    imem_address,
  output logic                   imem_read,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic [PC_WIDTH-1:0]    if_id_pc4,
  output logic [INSTR_WIDTH-1:0] if_id_instruction,
  output logic                   if_id_valid,
  output logic                   fetch_stall
);

  typedef enum logic {
    ST_RUN,
    ST_REDIRECT_PENDING
  } state_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    pc4;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{pc: '0, pc4: '0, instr: NOP_INSTR, valid: 1'b0};

  state_e              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pending_target_q;
  logic                imem_read_q;
  ifid_t               ifid_q;

  logic [PC_WIDTH-1:0] pc4_d;
  logic [PC_WIDTH-1:0] target_d;

  // Next sequential PC wraps naturally; redirect targets are forced word-aligned.
  assign pc4_d    = pc_q + PC_WIDTH'(4);
  assign target_d = {branch_jump_target[PC_WIDTH-1:2], 2'b00};

  assign imem_address      = pc_q;
  assign imem_read         = imem_read_q;
  assign if_id_pc          = ifid_q.pc;
  assign if_id_pc4         = ifid_q.pc4;
  assign if_id_instruction = ifid_q.instr;
  assign if_id_valid       = ifid_q.valid;
  assign fetch_stall       = (imem_read_q & imem_busywait) | (state_q == ST_REDIRECT_PENDING);

  // Fetch FSM: PC, pending redirect, fetch request and IF/ID register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      // NOTE: every state register uses non-blocking assignment so all of them
      // sample the pre-edge values; blocking here would chain updates within one edge.
      state_q          <= ST_RUN;
      pc_q             <= RESET_PC;
      pending_target_q <= '0;
      imem_read_q      <= 1'b0;
      ifid_q           <= BUBBLE;
    end else if (!imem_read_q) begin
      // First edge after reset only raises the request; nothing was fetched yet.
      imem_read_q <= 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (reset_IF_reg && !imem_busywait) begin
            pc_q   <= target_d;
            ifid_q <= BUBBLE;
          end else if (reset_IF_reg) begin
            // Address must stay put until the cache finishes; park the target.
            pending_target_q <= target_d;
            state_q          <= ST_REDIRECT_PENDING;
            ifid_q           <= BUBBLE;
          end else if (imem_busywait) begin
            if (!hold_IF_reg) ifid_q <= BUBBLE;
          end else if (hold_IF_reg) begin
            // Word is dropped; the same PC is fetched again next cycle.
          end else begin
            ifid_q <= '{pc: pc_q, pc4: pc4_d, instr: imem_instruction, valid: 1'b1};
            pc_q   <= pc4_d;
          end
        end
        ST_REDIRECT_PENDING: begin
          if (reset_IF_reg) pending_target_q <= target_d;
          if (reset_IF_reg || !hold_IF_reg) ifid_q <= BUBBLE;
          if (!imem_busywait) begin
            // Stale fetch has completed: its word is discarded, newest redirect wins.
            pc_q    <= reset_IF_reg ? target_d : pending_target_q;
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage_unit.sv
// Self-checking bench for if_stage_unit: directed scenarios plus random stimulus
// compared against a behavioural fetch-stage model.
module tb_if_stage_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK;
  logic        RESET;
  logic        reset_IF_reg;
  logic        hold_IF_reg;
  logic [31:0] branch_jump_target;
  logic        imem_busywait;
  logic [31:0] imem_instruction;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic        fetch_stall;

  // Second instance with a reset PC at the top of the address space.
  logic        w_rst;
  logic [31:0] w_instr;
  logic [31:0] w_addr;
  logic        w_read;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;
  logic [31:0] w_ifid_instr;
  logic        w_valid;
  logic        w_stall;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_instruction = imem_word(imem_address);
  assign w_instr          = imem_word(w_addr);

  if_stage_unit dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .reset_IF_reg       (reset_IF_reg),
    .hold_IF_reg        (hold_IF_reg),
    .branch_jump_target (branch_jump_target),
    .imem_busywait      (imem_busywait),
    .imem_instruction   (imem_instruction),
    .imem_address       (imem_address),
    .imem_read          (imem_read),
    .if_id_pc           (if_id_pc),
    .if_id_pc4          (if_id_pc4),
    .if_id_instruction  (if_id_instruction),
    .if_id_valid        (if_id_valid),
    .fetch_stall        (fetch_stall)
  );

  if_stage_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .CLK                (CLK),
    .RESET              (w_rst),
    .reset_IF_reg       (1'b0),
    .hold_IF_reg        (1'b0),
    .branch_jump_target (32'h0),
    .imem_busywait      (1'b0),
    .imem_instruction   (w_instr),
    .imem_address       (w_addr),
    .imem_read          (w_read),
    .if_id_pc           (w_pc),
    .if_id_pc4          (w_pc4),
    .if_id_instruction  (w_ifid_instr),
    .if_id_valid        (w_valid),
    .fetch_stall        (w_stall)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } entry_t;

  logic [31:0] m_pc;
  logic        m_read;
  logic        m_pend;
  logic [31:0] m_ptgt;
  entry_t      m_ifid;

  function automatic entry_t bubble();
    entry_t e;
    e.pc = 32'h0; e.pc4 = 32'h0; e.instr = NOP; e.valid = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_read = 1'b0; m_pend = 1'b0; m_ptgt = 32'h0; m_ifid = bubble();
  endtask

  // One rising edge of the fetch stage, following the stated priority rules.
  task automatic model_step(input logic rd, input logic hd, input logic [31:0] tgt, input logic bw);
    logic [31:0] t;
    t = tgt & 32'hFFFF_FFFC;
    if (!m_read) begin
      m_read = 1'b1;
    end else if (m_pend) begin
      if (rd) m_ptgt = t;
      if (rd || !hd) m_ifid = bubble();
      if (!bw) begin
        m_pc   = m_ptgt;
        m_pend = 1'b0;
      end
    end else if (rd) begin
      m_ifid = bubble();
      if (bw) begin
        m_ptgt = t;
        m_pend = 1'b1;
      end else begin
        m_pc = t;
      end
    end else if (bw) begin
      if (!hd) m_ifid = bubble();
    end else if (!hd) begin
      m_ifid.pc    = m_pc;
      m_ifid.pc4   = m_pc + 32'd4;
      m_ifid.instr = imem_word(m_pc);
      m_ifid.valid = 1'b1;
      m_pc         = m_pc + 32'd4;
    end
  endtask

  task automatic check_ifid();
    check("if_id_pc", if_id_pc, m_ifid.pc);
    check("if_id_pc4", if_id_pc4, m_ifid.pc4);
    check("if_id_instruction", if_id_instruction, m_ifid.instr);
    check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_ifid.valid});
  endtask

  // Drive one cycle of stimulus, check combinational outputs, clock, check IF/ID.
  task automatic cycle(input logic rd, input logic hd, input logic [31:0] tgt, input logic bw);
    reset_IF_reg       = rd;
    hold_IF_reg        = hd;
    branch_jump_target = tgt;
    imem_busywait      = bw;
    #1;
    check("imem_address", imem_address, m_pc);
    check("imem_read", {31'b0, imem_read}, {31'b0, m_read});
    check("fetch_stall", {31'b0, fetch_stall}, {31'b0, (m_read & bw) | m_pend});
    @(posedge CLK);
    model_step(rd, hd, tgt, bw);
    #1;
    check_ifid();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, imem_address, 32'h0);
    check({tag, "_read"}, {31'b0, imem_read}, 32'h0);
    check({tag, "_pc"}, if_id_pc, 32'h0);
    check({tag, "_pc4"}, if_id_pc4, 32'h0);
    check({tag, "_instr"}, if_id_instruction, NOP);
    check({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
    check({tag, "_stall"}, {31'b0, fetch_stall}, 32'h0);
  endtask

  initial begin
    RESET = 1'b1; w_rst = 1'b1;
    reset_IF_reg = 1'b0; hold_IF_reg = 1'b0;
    branch_jump_target = 32'h0; imem_busywait = 1'b0;
    model_reset();
    #12;
    check_reset_values("rst");
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Sequential fetch: first edge only raises imem_read, then 0,4,8,12.
    cycle(0, 0, 0, 0);
    check("first_edge_read", {31'b0, imem_read}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0);
      check("seq_pc", if_id_pc, 32'(i * 4));
    end

    // Load-use hold at PC=0x10.
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    check("hold_addr", imem_address, 32'h10);
    check("hold_ifid", if_id_pc, 32'h0C);
    cycle(0, 0, 0, 0);
    check("after_hold0", if_id_pc, 32'h10);
    cycle(0, 0, 0, 0);
    check("after_hold1", if_id_pc, 32'h14);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // Redirect with zero-wait cache at PC=0x20.
    check("pre_redirect_addr", imem_address, 32'h20);
    cycle(1, 0, 32'h100, 0);
    check("redir_bubble_instr", if_id_instruction, NOP);
    check("redir_pc", imem_address, 32'h100);
    cycle(0, 0, 0, 0);
    check("redir_target_ifid", if_id_pc, 32'h100);

    // Get to 0x40, then a 3-cycle miss with two redirects in flight.
    cycle(1, 0, 32'h40, 0);
    cycle(1, 0, 32'h200, 1);
    cycle(1, 0, 32'h300, 1);
    cycle(0, 0, 0, 1);
    check("miss_addr_stable", imem_address, 32'h40);
    cycle(0, 0, 0, 0);
    check("newest_redirect", imem_address, 32'h300);
    check("stale_word_dropped", {31'b0, if_id_valid}, 32'h0);
    cycle(0, 0, 0, 0);
    check("pending_target_ifid", if_id_pc, 32'h300);

    // Plain miss without and with hold.
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check("miss_bubble", {31'b0, if_id_valid}, 32'h0);
    cycle(0, 0, 0, 0);
    check("miss_resume", if_id_pc, 32'h304);
    cycle(0, 1, 0, 1);
    cycle(0, 1, 0, 1);
    check("miss_hold_keep", if_id_pc, 32'h304);
    cycle(0, 0, 0, 0);

    // Misaligned target is word-aligned.
    cycle(1, 0, 32'h103, 0);
    check("align_target", imem_address, 32'h100);

    // Reset while a redirect is pending.
    cycle(1, 0, 32'h200, 1);
    check("pending_stall", {31'b0, fetch_stall}, 32'h1);
    RESET = 1'b1;
    #1;
    check_reset_values("midrst");
    model_reset();
    @(posedge CLK); #1;
    RESET = 1'b0;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("restart_at_reset_pc", if_id_pc, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic rd, hd, bw;
      logic [31:0] tgt;
      rd  = ($urandom_range(0, 9) == 0);
      hd  = !rd && ($urandom_range(0, 6) == 0);
      bw  = ($urandom_range(0, 9) < 3);
      tgt = $urandom;
      cycle(rd, hd, tgt, bw);
    end

    // PC+4 wrap on the high-reset-PC instance.
    w_rst = 1'b0;
    @(posedge CLK); #1;
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    check("wrap_read", {31'b0, w_read}, 32'h1);
    @(posedge CLK); #1;
    check("wrap_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", w_pc4, 32'h0);
    check("wrap_valid", {31'b0, w_valid}, 32'h1);
    check("wrap_addr1", w_addr, 32'h0);
    @(posedge CLK); #1;
    check("wrap_next_pc", w_pc, 32'h0);
    check("wrap_next_pc4", w_pc4, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
